// File: rtl/pipelined_adder_subtractor.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits resolved CHUNK bits per stage,
// valid/ready streaming with per-beat mode, optional signed saturation and carry/overflow/zero flags.
module pipelined_adder_subtractor #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ctrl,
   input  logic             sat_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   logic adv;

   // Per-stage registered state
   logic             vld_q [STAGES];
   logic             sat_q [STAGES];
   logic             cy_q  [STAGES];
   logic [WIDTH-1:0] sum_q [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] bx_q  [STAGES];
   logic             ovf_q;
   logic             zero_q;

   // Per-stage inputs (ports for stage 0, previous stage register otherwise)
   logic             vld_in [STAGES];
   logic             sat_in [STAGES];
   logic             cy_in  [STAGES];
   logic [WIDTH-1:0] sum_in [STAGES];
   logic [WIDTH-1:0] a_in   [STAGES];
   logic [WIDTH-1:0] bx_in  [STAGES];

   logic             cy_nx  [STAGES];
   logic [WIDTH-1:0] sum_nx [STAGES];
   logic [WIDTH-1:0] raw_sum;
   logic             msb_cin;
   logic             ovf_nx;
   logic             zero_nx;

   assign adv       = !vld_q[LAST] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_q[LAST];
   assign s         = sum_q[LAST];
   assign cout      = cy_q[LAST];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

   // Resolves chunk k of the sum; returns {carry_out, partial sum with chunk k filled in}.
   function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] av,
                                           input logic [WIDTH-1:0] bv,
                                           input logic [WIDTH-1:0] sv,
                                           input logic             ci,
                                           input int unsigned      k);
      logic [CHUNK:0]   part;
      logic [WIDTH-1:0] r;
      part = {1'b0, av[k*CHUNK +: CHUNK]} + {1'b0, bv[k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, ci};
      r = sv;
      r[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      return {part[CHUNK], r};
   endfunction

   always_comb begin
      vld_in[0] = in_valid;
      sat_in[0] = sat_en;
      cy_in[0]  = ctrl;
      sum_in[0] = '0;
      a_in[0]   = a;
      bx_in[0]  = b ^ {WIDTH{ctrl}};
      for (int unsigned k = 1; k < STAGES; k++) begin
         vld_in[k] = vld_q[k-1];
         sat_in[k] = sat_q[k-1];
         cy_in[k]  = cy_q[k-1];
         sum_in[k] = sum_q[k-1];
         a_in[k]   = a_q[k-1];
         bx_in[k]  = bx_q[k-1];
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < STAGES; k++) begin
         {cy_nx[k], sum_nx[k]} = step(a_in[k], bx_in[k], sum_in[k], cy_in[k], k);
      end
      // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
      raw_sum = sum_nx[LAST];
      msb_cin = a_in[LAST][WIDTH-1] ^ bx_in[LAST][WIDTH-1] ^ raw_sum[WIDTH-1];
      ovf_nx  = msb_cin ^ cy_nx[LAST];
      if (ovf_nx && sat_in[LAST]) begin
         sum_nx[LAST] = a_in[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
      end
      zero_nx = (sum_nx[LAST] == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            vld_q[k] <= 1'b0;
            sat_q[k] <= 1'b0;
            cy_q[k]  <= 1'b0;
            sum_q[k] <= '0;
            a_q[k]   <= '0;
            bx_q[k]  <= '0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            vld_q[k] <= vld_in[k];
            sat_q[k] <= sat_in[k];
            cy_q[k]  <= cy_nx[k];
            sum_q[k] <= sum_nx[k];
            a_q[k]   <= a_in[k];
            bx_q[k]  <= bx_in[k];
         end
         ovf_q  <= ovf_nx;
         zero_q <= zero_nx;
      end
   end

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// Bench for pipelined_adder_subtractor: three configurations (16/4, 8/1, 32/8) driven in parallel
// and checked against a signed-arithmetic reference model with per-instance scoreboards.
module tb_pipelined_adder_subtractor;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        ctrl;
   logic        sat_en;
   logic        out_ready;
   logic [31:0] a;
   logic [31:0] b;

   logic        ir16, ov16, c16, o16, z16;
   logic        ir8,  ov8,  c8,  o8,  z8;
   logic        ir32, ov32, c32, o32, z32;
   logic [15:0] s16;
   logic [7:0]  s8;
   logic [31:0] s32;

   logic        ir [3];
   logic        ov [3];
   logic        oc [3];
   logic        oo [3];
   logic        oz [3];
   logic [31:0] os [3];

   int unsigned wid [3] = '{16, 8, 32};
   int unsigned lat [3] = '{4, 1, 8};

   int   tests    = 0;
   int   failures = 0;
   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];

   always #5 clk = ~clk;

   pipelined_adder_subtractor #(.WIDTH(16), .STAGES(4)) d16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
      .a(a[15:0]), .b(b[15:0]), .ctrl(ctrl), .sat_en(sat_en),
      .out_valid(ov16), .out_ready(out_ready), .s(s16), .cout(c16), .ovf(o16), .zero(z16)
   );

   pipelined_adder_subtractor #(.WIDTH(8), .STAGES(1)) d8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
      .a(a[7:0]), .b(b[7:0]), .ctrl(ctrl), .sat_en(sat_en),
      .out_valid(ov8), .out_ready(out_ready), .s(s8), .cout(c8), .ovf(o8), .zero(z8)
   );

   pipelined_adder_subtractor #(.WIDTH(32), .STAGES(8)) d32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
      .a(a), .b(b), .ctrl(ctrl), .sat_en(sat_en),
      .out_valid(ov32), .out_ready(out_ready), .s(s32), .cout(c32), .ovf(o32), .zero(z32)
   );

   assign ir[0] = ir16;  assign ir[1] = ir8;  assign ir[2] = ir32;
   assign ov[0] = ov16;  assign ov[1] = ov8;  assign ov[2] = ov32;
   assign oc[0] = c16;   assign oc[1] = c8;   assign oc[2] = c32;
   assign oo[0] = o16;   assign oo[1] = o8;   assign oo[2] = o32;
   assign oz[0] = z16;   assign oz[1] = z8;   assign oz[2] = z32;
   assign os[0] = {16'h0, s16};
   assign os[1] = {24'h0, s8};
   assign os[2] = s32;

   // Reference: exact signed result, range-checked; carry from unsigned compare.
   function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                  input logic sub, input logic sat, input int unsigned w);
      exp_t   e;
      longint mask, ua, ub, sa, sb, exact, maxv, minv, res;
      mask  = (longint'(1) << w) - 1;
      maxv  = (longint'(1) << (w - 1)) - 1;
      minv  = -(longint'(1) << (w - 1));
      ua    = longint'(av) & mask;
      ub    = longint'(bv) & mask;
      sa    = (ua > maxv) ? ua - (mask + 1) : ua;
      sb    = (ub > maxv) ? ub - (mask + 1) : ub;
      exact = sub ? sa - sb : sa + sb;
      e.o   = (exact > maxv) || (exact < minv);
      e.c   = sub ? (ua >= ub) : (ua + ub > mask);
      res   = exact;
      if (sat && e.o) res = (exact > maxv) ? maxv : minv;
      e.s   = 32'(res & mask);
      e.z   = (e.s == 32'h0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int qsize(input int i);
      case (i)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic void qpush(input int i, input exp_t e);
      case (i)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endfunction

   function automatic exp_t qpop(input int i);
      case (i)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   task automatic check_idle(input string when);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s d%0d out_valid", when, wid[i]), ov[i], 0);
         chk($sformatf("%s d%0d s", when, wid[i]), os[i], 0);
         chk($sformatf("%s d%0d cout", when, wid[i]), oc[i], 0);
         chk($sformatf("%s d%0d ovf", when, wid[i]), oo[i], 0);
         chk($sformatf("%s d%0d zero", when, wid[i]), oz[i], 0);
         chk($sformatf("%s d%0d in_ready", when, wid[i]), ir[i], 1);
      end
   endtask

   // One beat into an empty pipe; checks exact latency and result for every instance.
   // The 16-bit instance is checked against literal expectations.
   task automatic directed(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic c, input logic sa, input logic [15:0] es,
                           input logic ec, input logic eo, input logic ez);
      exp_t e;
      in_valid  = 1'b1;
      a         = av;
      b         = bv;
      ctrl      = c;
      sat_en    = sa;
      out_ready = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("%s d%0d in_ready", tag, wid[i]), ir[i], 1);
      for (int n = 1; n <= 9; n++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s d%0d out_valid edge %0d", tag, wid[i], n), ov[i], (n == lat[i]));
            if (n == lat[i]) begin
               if (i == 0) begin
                  chk($sformatf("%s d16 s", tag), os[i], {16'h0, es});
                  chk($sformatf("%s d16 cout", tag), oc[i], ec);
                  chk($sformatf("%s d16 ovf", tag), oo[i], eo);
                  chk($sformatf("%s d16 zero", tag), oz[i], ez);
               end else begin
                  e = model(av, bv, c, sa, wid[i]);
                  chk($sformatf("%s d%0d s", tag, wid[i]), os[i], e.s);
                  chk($sformatf("%s d%0d cout", tag, wid[i]), oc[i], e.c);
                  chk($sformatf("%s d%0d ovf", tag, wid[i]), oo[i], e.o);
                  chk($sformatf("%s d%0d zero", tag, wid[i]), oz[i], e.z);
               end
            end
         end
      end
   endtask

   task automatic stream_cycle(input bit drain);
      bit   acc   [3];
      bit   stall [3];
      exp_t held  [3];
      exp_t e;
      if (drain) begin
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end else begin
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = $urandom;
         b         = $urandom;
         ctrl      = 1'($urandom_range(0, 1));
         sat_en    = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
      end
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stream d%0d in_ready", wid[i]), ir[i], !(ov[i] && !out_ready));
         if (ov[i] && out_ready) begin
            if (qsize(i) == 0) begin
               chk($sformatf("stream d%0d unexpected out_valid", wid[i]), ov[i], 0);
            end else begin
               e = qpop(i);
               chk($sformatf("stream d%0d s", wid[i]), os[i], e.s);
               chk($sformatf("stream d%0d cout", wid[i]), oc[i], e.c);
               chk($sformatf("stream d%0d ovf", wid[i]), oo[i], e.o);
               chk($sformatf("stream d%0d zero", wid[i]), oz[i], e.z);
            end
         end
         acc[i]   = in_valid && ir[i];
         stall[i] = ov[i] && !out_ready;
         held[i]  = '{os[i], oc[i], oo[i], oz[i]};
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (stall[i]) begin
            chk($sformatf("stall d%0d out_valid", wid[i]), ov[i], 1);
            chk($sformatf("stall d%0d s", wid[i]), os[i], held[i].s);
            chk($sformatf("stall d%0d cout", wid[i]), oc[i], held[i].c);
            chk($sformatf("stall d%0d ovf", wid[i]), oo[i], held[i].o);
            chk($sformatf("stall d%0d zero", wid[i]), oz[i], held[i].z);
         end
         if (acc[i]) qpush(i, model(a, b, ctrl, sat_en, wid[i]));
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      ctrl      = 1'b0;
      sat_en    = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle("reset");

      directed("add",      32'h0000_1234, 32'h0000_0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
      directed("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      directed("sub_zero", 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      directed("ovf_wrap", 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      directed("ovf_satp", 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      directed("ovf_satn", 32'h0000_8000, 32'h0000_0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
      directed("carry_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

      for (int cyc = 0; cyc < 400; cyc++) stream_cycle(1'b0);
      for (int cyc = 0; cyc < 12; cyc++) stream_cycle(1'b1);
      for (int i = 0; i < 3; i++) chk($sformatf("drain d%0d leftover beats", wid[i]), qsize(i), 0);

      // Three beats in flight, then a reset edge with in_valid still high.
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         a        = $urandom;
         b        = $urandom;
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      check_idle("midreset");
      directed("post_reset", 32'h0000_1234, 32'h0000_0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_adder_subtractor.md
Name: pipelined_adder_subtractor

Overview:
- Parametrised, pipelined two's-complement adder/subtractor. Successor to the fixed-width ripple adder-subtractor.
- Splits a WIDTH-bit add/subtract into STAGES registered carry-chunks and streams operands through a valid/ready handshake.
- Per-beat mode select, optional signed saturation, and carry/overflow/zero flags.
- Used as the datapath arithmetic unit in streaming blocks that need full throughput at wide widths.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be ≥ 2.
- STAGES, 4, number of pipeline stages; equals the latency in cycles. Must be ≥ 1, and WIDTH % STAGES == 0.
- CHUNK, WIDTH/STAGES, bits resolved per stage. Derived localparam; not user-overridable.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ctrl  in  1  0 = A+B, 1 = A−B (implemented as A + ~B + 1).
- sat_en  in  1  1 = saturate the result on signed overflow.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- s  out  WIDTH  result (saturated if selected).
- cout  out  1  raw carry out of the MSB. For subtract, 1 = no borrow.
- ovf  out  1  signed overflow of the unsaturated result.
- zero  out  1  final s == 0.

Behaviour:
- Reset (clk edge with rst=1):
  - All stage valid bits and out_valid clear to 0.
  - s, cout, ovf and zero clear to 0.
  - Any in-flight beats are discarded.
  - in_ready is 1 in the first cycle after reset.
  - rst has priority over every other input.
- Advance condition: adv = !out_valid || out_ready. All stages shift together when adv=1 and hold when adv=0.
- in_ready = adv, combinational. A beat is accepted on an edge where in_valid && in_ready.
- When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0. Bubbles shift like data.
- Each beat carries its own ctrl and sat_en through the pipe. Changing the mode between beats is legal.
- Stage k (0..STAGES−1):
  - Adds A[k*CHUNK +: CHUNK] and (B^{WIDTH{ctrl}})[k*CHUNK +: CHUNK] with carry-in.
  - Carry-in is the registered carry from stage k−1; for stage 0 it is ctrl.
  - Registers the chunk sum, the carry out, and the still-unused upper operand chunks.
  - Lower sum chunks already computed shift forward unchanged.
- Final stage, on the unsaturated sum r:
  - cout = carry out of bit WIDTH−1.
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Saturation:
  - If sat_en=1 and ovf=1: s = A[WIDTH−1] ? {1,0…0} : {0,1…1}.
  - Otherwise s = r.
  - cout and ovf always report the raw, unsaturated result.
  - zero reflects the final s.
- Latency: a beat accepted on edge t presents on the outputs with out_valid=1 after edge t+STAGES−1. That is STAGES edges inclusive of the accept edge.
  - With STAGES=1, the result registers directly from the inputs.
- Throughput: one beat per cycle while out_ready=1.
- Stalls:
  - While out_valid=1 and out_ready=0, s/cout/ovf/zero/out_valid hold stable and in_ready=0.
  - No beat is dropped, duplicated or reordered.
- Simultaneous events: on one edge, output handshake completion and input acceptance both occur when out_valid && out_ready && in_valid.
- Data inputs are don't-care when in_valid=0. Outputs are don't-care (but must be stable) when out_valid=0.

Test Plan:
- WIDTH=16, STAGES=4; add 0x1234 + 0x0FFF, sat_en=0 -> s=0x2233, cout=0, ovf=0, zero=0, out_valid exactly 4 edges after accept.
- Sub 0x0005 − 0x0007 -> s=0xFFFE, cout=0, ovf=0. Sub 0x0005 − 0x0005 -> s=0x0000, cout=1, zero=1.
- Add 0x7FFF + 0x0001: sat_en=0 -> s=0x8000, ovf=1; sat_en=1 -> s=0x7FFF, ovf=1. Sub 0x8000 − 0x0001 with sat_en=1 -> s=0x8000, ovf=1, cout=1.
- Stream 100 random beats with random ctrl/sat_en, in_valid random, out_ready toggling 50% -> outputs match the reference model in order; no loss or duplication; outputs stable during stalls; in_ready=0 exactly when out_valid && !out_ready.
- Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 and all outputs 0 after that edge; the next accepted beat emerges with correct latency.
- Rerun the above with (WIDTH=8, STAGES=1) and (WIDTH=32, STAGES=8); carry across every chunk boundary via 0xFFFFFFFF + 1 -> s=0, cout=1, zero=1.
